// File: rtl/timer_multi_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, CTRL layout
// and helpers for locating the global registers after the channel block.
package timer_multi_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LOAD  = 2'd1;
    localparam logic [1:0] REG_VALUE = 2'd2;
    localparam logic [1:0] REG_CMP   = 2'd3;

    // Global registers sit directly after the last channel's four words.
    localparam int STATUS_REL = 0;
    localparam int PRESC_REL  = 1;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_PWM_EN   = 3;
    localparam int CTRL_W        = 4;

    typedef struct packed {
        logic pwm_en;
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic int status_ofs(input int num_ch);
        return num_ch * 4 + STATUS_REL;
    endfunction

    function automatic int presc_ofs(input int num_ch);
        return num_ch * 4 + PRESC_REL;
    endfunction

endpackage

// File: rtl/timer_multi_if.sv
// IO-page bus between the SoC decoder (master) and the timer block (slave).
interface timer_multi_if #(
    parameter int ADDR_W = 4
);
    logic              sel;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output sel, wr_en, rd_en, addr, wdata, input rdata);
    modport slave  (input sel, wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/LOAD/VALUE/CMP registers, count and
// reload on prescaler ticks, registered timeout pulse and PWM output.
module timer_channel
    import timer_multi_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [1:0]       reg_sel,
    input  logic [31:0]      wdata,
    output ctrl_t            ctrl,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] cmp,
    output logic             expire,
    output logic             timeout,
    output logic             pwm
);

    ctrl_t            ctrl_r;
    logic [CNT_W-1:0] load_r;
    logic [CNT_W-1:0] value_r;
    logic [CNT_W-1:0] cmp_r;
    logic             timeout_r;
    logic             pwm_r;
    logic             expire_s;

    assign expire_s = tick & ctrl_r.en & (value_r == {CNT_W{1'b0}});

    // Count/reload first, then let bus writes override so a write always wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_r    <= '0;
            load_r    <= {CNT_W{1'b0}};
            value_r   <= {CNT_W{1'b0}};
            cmp_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
            pwm_r     <= 1'b0;
        end else begin
            timeout_r <= expire_s;
            pwm_r     <= ctrl_r.en & ctrl_r.pwm_en & (value_r < cmp_r);
            if (expire_s) begin
                if (ctrl_r.periodic) begin
                    value_r <= load_r;
                end else begin
                    ctrl_r.en <= 1'b0;
                end
            end else if (tick && ctrl_r.en) begin
                value_r <= value_r - CNT_W'(1);
            end
            if (wr_en) begin
                case (reg_sel)
                    REG_CTRL: begin
                        ctrl_r <= ctrl_t'(wdata[CTRL_W-1:0]);
                        // Only a 0->1 transition of EN restarts from LOAD.
                        if (wdata[CTRL_EN] && !ctrl_r.en) begin
                            value_r <= load_r;
                        end
                    end
                    REG_LOAD:  load_r  <= wdata[CNT_W-1:0];
                    REG_VALUE: value_r <= wdata[CNT_W-1:0];
                    REG_CMP:   cmp_r   <= wdata[CNT_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    assign ctrl    = ctrl_r;
    assign load    = load_r;
    assign value   = value_r;
    assign cmp     = cmp_r;
    assign expire  = expire_s;
    assign timeout = timeout_r;
    assign pwm     = pwm_r;

endmodule

// File: rtl/timer_multi_ip.sv
// Multi-channel timer peripheral: shared prescaler, address decode, sticky
// W1C STATUS with maskable interrupt, and the registered read mux.
module timer_multi_ip
    import timer_multi_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    timer_multi_if.slave      bus,
    output logic [NUM_CH-1:0] timeout_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq_o
);

    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_ofs(NUM_CH));
    localparam logic [ADDR_W-1:0] PRESC_ADDR  = ADDR_W'(presc_ofs(NUM_CH));

    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_cnt_r;
    logic [NUM_CH-1:0]  status_r;
    logic [31:0]        rdata_r;

    logic               tick_s;
    logic               wr_s;
    logic               rd_s;
    logic               presc_wr_s;
    logic [ADDR_W-3:0]  ch_idx_s;
    logic [1:0]         reg_sel_s;
    logic [NUM_CH-1:0]  status_clr_s;
    logic [NUM_CH-1:0]  expire_s;
    logic [NUM_CH-1:0]  irq_en_s;
    logic [31:0]        ch_word_s [NUM_CH];
    logic [31:0]        chan_rd_s;
    logic [31:0]        rdata_s;

    assign wr_s       = bus.sel & bus.wr_en;
    assign rd_s       = bus.sel & bus.rd_en;
    assign ch_idx_s   = bus.addr[ADDR_W-1:2];
    assign reg_sel_s  = bus.addr[1:0];
    assign presc_wr_s = wr_s & (bus.addr == PRESC_ADDR);
    assign tick_s     = (presc_cnt_r == presc_r);

    function automatic logic [31:0] chan_word(input logic [1:0] rs, input ctrl_t c,
                                              input logic [CNT_W-1:0] ld,
                                              input logic [CNT_W-1:0] vl,
                                              input logic [CNT_W-1:0] cp);
        logic [31:0] w;
        case (rs)
            REG_CTRL:  w = 32'(c);
            REG_LOAD:  w = 32'(ld);
            REG_VALUE: w = 32'(vl);
            REG_CMP:   w = 32'(cp);
            default:   w = 32'd0;
        endcase
        return w;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ctrl_t            ctrl_s;
        logic [CNT_W-1:0] load_s;
        logic [CNT_W-1:0] value_s;
        logic [CNT_W-1:0] cmp_s;
        logic             ch_wr_s;

        assign ch_wr_s = wr_s & (ch_idx_s == (ADDR_W-2)'(c));

        timer_channel #(.CNT_W(CNT_W)) u_channel (
            .clk     (clk),
            .resetn  (resetn),
            .tick    (tick_s),
            .wr_en   (ch_wr_s),
            .reg_sel (reg_sel_s),
            .wdata   (bus.wdata),
            .ctrl    (ctrl_s),
            .load    (load_s),
            .value   (value_s),
            .cmp     (cmp_s),
            .expire  (expire_s[c]),
            .timeout (timeout_o[c]),
            .pwm     (pwm_o[c])
        );

        assign irq_en_s[c]  = ctrl_s.irq_en;
        assign ch_word_s[c] = (ch_idx_s == (ADDR_W-2)'(c)) ?
                              chan_word(reg_sel_s, ctrl_s, load_s, value_s, cmp_s) : 32'd0;
    end

    // Combine the per-channel words; at most one is non-zero for any address.
    always_comb begin
        chan_rd_s = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            chan_rd_s = chan_rd_s | ch_word_s[c];
        end
    end

    // Read mux over globals and channels; unmapped offsets fall through to 0.
    always_comb begin
        rdata_s      = 32'd0;
        status_clr_s = (wr_s && (bus.addr == STATUS_ADDR)) ? bus.wdata[NUM_CH-1:0] : {NUM_CH{1'b0}};
        if (bus.addr == STATUS_ADDR) begin
            rdata_s = 32'(status_r);
        end else if (bus.addr == PRESC_ADDR) begin
            rdata_s = 32'(presc_r);
        end else begin
            rdata_s = chan_rd_s;
        end
    end

    // Prescaler, sticky STATUS (a new expiry beats W1C) and read data capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_r     <= {PRESC_W{1'b0}};
            presc_cnt_r <= {PRESC_W{1'b0}};
            status_r    <= {NUM_CH{1'b0}};
            rdata_r     <= 32'd0;
        end else begin
            if (presc_wr_s) begin
                presc_r     <= bus.wdata[PRESC_W-1:0];
                presc_cnt_r <= {PRESC_W{1'b0}};
            end else if (tick_s) begin
                presc_cnt_r <= {PRESC_W{1'b0}};
            end else begin
                presc_cnt_r <= presc_cnt_r + PRESC_W'(1);
            end
            status_r <= (status_r & ~status_clr_s) | expire_s;
            if (rd_s) begin
                rdata_r <= rdata_s;
            end
        end
    end

    assign bus.rdata = rdata_r;
    assign irq_o     = |(status_r & irq_en_s);

endmodule

// File: tb/tb_timer_multi_ip.sv
// Directed bench for timer_multi_ip (NUM_CH=2): register map table plus
// hand-timed sequences for reset, one-shot, periodic, PWM and collisions.
module tb_timer_multi_ip;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NUM_CH-1:0] timeout_o;
    logic [NUM_CH-1:0] pwm_o;
    logic              irq_o;

    int nvec  = 0;
    int nfail = 0;

    timer_multi_if #(.ADDR_W(ADDR_W)) bus ();

    timer_multi_ip #(.NUM_CH(NUM_CH), .CNT_W(32), .PRESC_W(16), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .timeout_o (timeout_o),
        .pwm_o     (pwm_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } map_vec_t;

    map_vec_t map_tbl [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.sel   = 1'b1;
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.sel   = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.sel   = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = a;
        @(negedge clk);
        bus.sel   = 1'b0;
        bus.rd_en = 1'b0;
        d = bus.rdata;
    endtask

    initial begin
        logic [31:0] r;
        int pulses;
        int idx;
        int first;
        int last;
        int bad;
        int highs;
        int seen;
        logic [31:0] pat;

        pat = 32'hA5A5_A5A5;
        for (int i = 0; i < 16; i++) begin
            map_tbl[i].addr = 4'(i);
            map_tbl[i].exp  = 32'd0;
        end
        map_tbl[0].exp = 32'h0000_0005;
        map_tbl[1].exp = pat;
        map_tbl[2].exp = pat;
        map_tbl[3].exp = pat;
        map_tbl[4].exp = 32'h0000_0005;
        map_tbl[5].exp = pat;
        map_tbl[6].exp = pat;
        map_tbl[7].exp = pat;
        map_tbl[8].exp = 32'h0000_0000;
        map_tbl[9].exp = 32'h0000_A5A5;

        resetn    = 1'b0;
        bus.sel   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = 4'd0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_rdata",   bus.rdata, 32'd0);
        check("reset_timeout", 32'(timeout_o), 32'd0);
        check("reset_pwm",     32'(pwm_o), 32'd0);
        check("reset_irq",     32'(irq_o), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Reset asserted while ch0 VALUE=2 aborts the count.
        wr(4'd1, 32'd5);
        wr(4'd0, 32'h0000_0005);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_timeout", 32'(timeout_o), 32'd0);
        check("midrst_irq",     32'(irq_o), 32'd0);
        check("midrst_rdata",   bus.rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rd(4'd0, r); check("midrst_ctrl",   r, 32'd0);
        rd(4'd1, r); check("midrst_load",   r, 32'd0);
        rd(4'd2, r); check("midrst_value",  r, 32'd0);
        rd(4'd8, r); check("midrst_status", r, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (timeout_o != 2'b00) seen++;
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);

        // One-shot ch0, LOAD=3, PRESC=0: expiry 4 clocks after the CTRL write edge.
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h0000_0005);
        pulses = 0;
        idx    = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (timeout_o[0]) begin
                pulses++;
                idx = k;
            end
        end
        check("oneshot_pulses", 32'(pulses), 32'd1);
        check("oneshot_when",   32'(idx), 32'd4);
        check("oneshot_irq",    32'(irq_o), 32'd1);
        rd(4'd0, r); check("oneshot_ctrl",   r, 32'h0000_0004);
        rd(4'd2, r); check("oneshot_value",  r, 32'd0);
        rd(4'd8, r); check("oneshot_status", r, 32'h0000_0001);
        wr(4'd8, 32'h0000_0001);
        check("oneshot_irq_clr", 32'(irq_o), 32'd0);

        // Periodic ch1, LOAD=1, PRESC=2: period 6, VALUE read continuously.
        wr(4'd9, 32'd2);
        wr(4'd5, 32'd1);
        wr(4'd4, 32'h0000_0003);
        bus.sel   = 1'b1;
        bus.rd_en = 1'b1;
        bus.addr  = 4'd6;
        pulses = 0;
        first  = 0;
        last   = 0;
        bad    = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("periodic_value", bus.rdata, ((((k - 1) + 2) / 3) % 2 == 0) ? 32'd1 : 32'd0);
            if (timeout_o[1]) begin
                if (pulses == 0) first = k;
                else if (k - last != 6) bad++;
                last = k;
                pulses++;
            end
        end
        bus.sel   = 1'b0;
        bus.rd_en = 1'b0;
        check("periodic_pulses",   32'(pulses), 32'd5);
        check("periodic_first",    32'(first), 32'd4);
        check("periodic_interval", 32'(bad), 32'd0);
        wr(4'd4, 32'd0);
        wr(4'd9, 32'd0);
        wr(4'd8, 32'h0000_0003);

        // PWM ch0: LOAD=9, CMP=3 -> 3 of 10; then CMP=0 and CMP=12.
        wr(4'd1, 32'd9);
        wr(4'd3, 32'd3);
        wr(4'd0, 32'h0000_000B);
        repeat (3) @(negedge clk);
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pwm_o[0]) highs++;
        end
        check("pwm_duty",   32'(highs), 32'd9);
        check("pwm_no_irq", 32'(irq_o), 32'd0);
        wr(4'd3, 32'd0);
        repeat (2) @(negedge clk);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pwm_o[0]) highs++;
        end
        check("pwm_cmp0", 32'(highs), 32'd0);
        wr(4'd3, 32'd12);
        repeat (2) @(negedge clk);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pwm_o[0]) highs++;
        end
        check("pwm_cmp12", 32'(highs), 32'd20);
        wr(4'd0, 32'd0);
        wr(4'd8, 32'h0000_0003);
        rd(4'd8, r); check("pwm_status_clr", r, 32'd0);

        // W1C of bit0 landing on the expiry edge: set wins.
        wr(4'd1, 32'd3);
        wr(4'd0, 32'h0000_0005);
        repeat (3) @(negedge clk);
        wr(4'd8, 32'h0000_0001);
        rd(4'd8, r); check("w1c_vs_expire", r, 32'h0000_0001);
        wr(4'd8, 32'h0000_0001);
        rd(4'd8, r); check("w1c_clear", r, 32'd0);

        // CTRL write clearing EN on the expiry edge: EN clears, STATUS still set.
        wr(4'd0, 32'h0000_0003);
        repeat (3) @(negedge clk);
        wr(4'd0, 32'd0);
        check("ctrlclr_pulse", 32'(timeout_o[0]), 32'd1);
        rd(4'd0, r); check("ctrlclr_ctrl",   r, 32'd0);
        rd(4'd8, r); check("ctrlclr_status", r, 32'h0000_0001);
        wr(4'd8, 32'h0000_0001);

        // VALUE write on a tick cycle wins over the decrement.
        wr(4'd1, 32'd20);
        wr(4'd0, 32'h0000_0003);
        repeat (2) @(negedge clk);
        wr(4'd2, 32'd7);
        rd(4'd2, r); check("valwr_read", r, 32'd7);
        rd(4'd2, r); check("valwr_next", r, 32'd6);
        wr(4'd0, 32'd0);
        wr(4'd8, 32'h0000_0003);

        // Register map: PRESC first so no tick disturbs the readback.
        wr(4'd9, pat);
        for (int i = 0; i < 16; i++) begin
            if (i != 9) wr(4'(i), pat);
        end
        for (int i = 0; i < 16; i++) begin
            rd(map_tbl[i].addr, r);
            check($sformatf("map_ofs%0d", i), r, map_tbl[i].exp);
        end
        rd(4'd9, r);
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.rdata, 32'h0000_A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/timer_multi_ip.md
Name: timer_multi_ip

Overview:
Memory-mapped multi-channel down-counting timer peripheral that sits on the SoC IO page, behind the same sel/wr_en/rd_en/addr/wdata/rdata bus as the single-channel timer.
- NUM_CH independent channels share one programmable prescaler.
- Each channel supports one-shot or periodic (auto-reload) mode, a compare register driving a PWM output, and a sticky timeout status bit.
- Status bits are write-1-to-clear and combine into one maskable interrupt line.

Parameters:
NUM_CH, 2, number of timer channels (1..8)
CNT_W, 32, counter/LOAD/CMP width in bits (<=32)
PRESC_W, 16, prescaler width in bits (<=32)
ADDR_W, 4, word-address width; must satisfy NUM_CH*4+2 <= 2**ADDR_W

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
sel  in  1  block selected by SoC address decode
wr_en  in  1  full-word write strobe (qualified by sel)
rd_en  in  1  read strobe (qualified by sel)
addr  in  ADDR_W  word offset within block
wdata  in  32  write data
rdata  out  32  registered read data
timeout_o  out  NUM_CH  one-cycle pulse per channel on expiry
pwm_o  out  NUM_CH  per-channel PWM output
irq_o  out  1  level interrupt = |(STATUS & IRQ_EN mask)

Behaviour:
- Reset is synchronous, active-low, on clk. In reset:
  - all CTRL, LOAD, VALUE, CMP, STATUS, PRESC and the prescaler counter are 0;
  - rdata = 0, timeout_o = 0, pwm_o = 0, irq_o = 0.
  - Reset asserted mid-count aborts the count immediately; no timeout pulse is emitted.
- Register map, word offsets:
  - Channel c at c*4 + r: r=0 CTRL, r=1 LOAD, r=2 VALUE, r=3 CMP.
  - Global at NUM_CH*4: STATUS (bit c = channel c expired; write-1-to-clear).
  - Global at NUM_CH*4+1: PRESC.
  - Unmapped offsets read 0; writes to them are ignored.
- CTRL bits: [0] EN, [1] PERIODIC, [2] IRQ_EN, [3] PWM_EN. Other bits read 0.
- Prescaler:
  - Counter runs from 0 to PRESC. The tick is asserted in the cycle the counter equals PRESC, then the counter wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - Any write to PRESC clears the prescaler counter in the same cycle.
- Channel start: a CTRL write with EN going 0->1 loads VALUE <= LOAD. Counting begins on the next tick.
- Channel count, on a tick with EN=1:
  - VALUE != 0: VALUE decrements by 1.
  - VALUE == 0:
    - set STATUS[c] and pulse timeout_o[c] for exactly one clk;
    - if PERIODIC=1: VALUE <= LOAD;
    - if PERIODIC=0: EN <= 0 and VALUE stays 0.
  - Period is therefore (LOAD+1)*(PRESC+1) clks.
- EN=0 freezes VALUE. Re-setting EN reloads VALUE from LOAD.
- PWM: pwm_o[c] = EN & PWM_EN & (VALUE < CMP), registered with 1-cycle latency.
  - CMP=0 gives constant low.
  - CMP>LOAD gives constant high while running.
- Bus write: takes effect at the clk edge where sel&wr_en.
  - LOAD written while running is used at the next reload only.
  - A direct VALUE write is allowed.
- Bus read: when sel&rd_en, rdata is registered at that edge and is valid the following cycle; it holds until the next read.
  - Narrow registers are zero-extended.
  - VALUE reads return the pre-update value of the read cycle.
- Simultaneous events:
  - VALUE write and tick in the same cycle: the write wins.
  - STATUS W1C and a new expiry of the same channel in the same cycle: set wins.
  - CTRL write clearing EN and an expiry in the same cycle: EN clears, and STATUS is still set.
- irq_o is combinational from registered STATUS and IRQ_EN; it remains high until cleared via W1C or IRQ_EN=0.

Decomposition:
- Package timer_multi_pkg holds:
  - register offset constants (CTRL=0, LOAD=1, VALUE=2, CMP=3, STATUS_OFS, PRESC_OFS);
  - CTRL bit indices;
  - the ctrl struct/typedef.
- Sub-module timer_channel (one per channel, generate loop) contains VALUE/LOAD/CMP/CTRL regs, the count/reload logic, timeout pulse and PWM.
- The top holds the prescaler, address decode, STATUS and the read mux.

Test Plan:
- Reset mid-count: PRESC=0, LOAD=5, EN=1; assert resetn=0 at VALUE=2 -> next cycle all regs 0, no timeout_o pulse, irq_o=0.
- One-shot: PRESC=0, ch0 LOAD=3, CTRL=0x5 -> timeout_o[0] pulses exactly 4 clks after the first tick; EN reads 0; STATUS=0x1; irq_o=1; writing STATUS=0x1 clears irq_o next cycle.
- Periodic with prescaler: PRESC=2, ch1 LOAD=1, CTRL=0x3 -> timeout_o[1] pulses every 6 clks over 5 periods; VALUE sequence 1,0,1,0.
- PWM: PRESC=0, LOAD=9, CMP=3, CTRL=0xB -> pwm_o[0] high 3 of every 10 clks; CMP=0 -> constant low; CMP=12 -> constant high.
- Collision: issue a STATUS W1C of bit0 in the exact cycle ch0 expires -> STATUS[0] remains 1. Write VALUE=7 on a tick cycle -> read returns 7.
- Register map: write/readback of every offset for NUM_CH=2 with pattern 0xA5A5A5A5 -> CTRL reads 0x5; unmapped offsets 10..15 read 0; rdata valid 1 cycle after rd_en.
